// File: rtl/bit_field_sequencer_if.sv
// Stream/config bundle for bit_field_sequencer: word input, slice output, field-table writes.
// master = producer/consumer side, slave = sequencer side.
interface bit_field_sequencer_if #(
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 16,
    parameter int NUM_FIELDS = 4
);
    localparam int LSB_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NUM_FIELDS);
    localparam int WID_W = $clog2(OUT_W + 1);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [LSB_W-1:0]  cfg_lsb;
    logic [WID_W-1:0]  cfg_width;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output cfg_we, cfg_idx, cfg_lsb, cfg_width, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_lsb, cfg_width, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/bit_field_sequencer.sv
// Slices each accepted word into up to NUM_FIELDS fields, one per cycle; first slice one cycle after accept.
// Stalled slices hold all outputs and block input; the next word is taken on the last-slice handshake.
module bit_field_sequencer #(
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 16,
    parameter int NUM_FIELDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bit_field_sequencer_if.slave bus,
    output logic                 busy,
    output logic [15:0]          words_done
);
    localparam int LSB_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NUM_FIELDS);
    localparam int WID_W = $clog2(OUT_W + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_nxt;
    logic [LSB_W-1:0]  live_lsb [NUM_FIELDS];
    logic [WID_W-1:0]  live_wid [NUM_FIELDS];
    logic [LSB_W-1:0]  sh_lsb   [NUM_FIELDS];
    logic [WID_W-1:0]  sh_wid   [NUM_FIELDS];
    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    logic              any_live, has_next, last, accept, load, drop, slice_hs;
    logic [IDX_W-1:0]  first_live, next_idx;
    logic [WID_W-1:0]  wid_clamped;
    logic [OUT_W-1:0]  shifted, mask;

    // Enable scans: lowest live entry for a new word, next shadow entry above the current one.
    always_comb begin
        any_live   = 1'b0;
        first_live = '0;
        has_next   = 1'b0;
        next_idx   = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (live_wid[i] != '0) begin
                any_live   = 1'b1;
                first_live = IDX_W'(i);
            end
            if (sh_wid[i] != '0 && i > int'(idx_q)) begin
                has_next = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        last     = (state == EMIT) && !has_next;
        slice_hs = (state == EMIT) && bus.out_ready;
        accept   = bus.in_valid && bus.in_ready;
        load     = accept && any_live;
        drop     = accept && !any_live;
        wid_clamped = (bus.cfg_width > WID_W'(OUT_W)) ? WID_W'(OUT_W) : bus.cfg_width;
        // Shift zero-fills above the word; a full-width mask falls out of the 16-bit shift overflowing.
        shifted  = OUT_W'(word_q >> sh_lsb[idx_q]);
        mask     = ~({OUT_W{1'b1}} << sh_wid[idx_q]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = EMIT;
            EMIT: if (slice_hs && last) state_nxt = load ? EMIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == EMIT);
        busy          = (state == EMIT);
        bus.in_ready  = (state == IDLE) || ((state == EMIT) && bus.out_ready && last);
        bus.out_last  = last;
        bus.out_idx   = idx_q;
        bus.out_data  = shifted & mask;
    end

    // Shadow copies the pre-write live table, so a write on the accept cycle lands on the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                live_lsb[i] <= '0;
                live_wid[i] <= '0;
                sh_lsb[i]   <= '0;
                sh_wid[i]   <= '0;
            end
            word_q     <= '0;
            idx_q      <= '0;
            words_done <= '0;
        end else begin
            if (bus.cfg_we) begin
                live_lsb[bus.cfg_idx] <= bus.cfg_lsb;
                live_wid[bus.cfg_idx] <= wid_clamped;
            end
            if (load) begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    sh_lsb[i] <= live_lsb[i];
                    sh_wid[i] <= live_wid[i];
                end
                word_q <= bus.in_data;
                idx_q  <= first_live;
            end else if (slice_hs && !last) begin
                idx_q <= next_idx;
            end
            words_done <= words_done + 16'(slice_hs && last) + 16'(drop);
        end
    end
endmodule

// File: tb/tb_bit_field_sequencer.sv
// Randomized scoreboard bench for bit_field_sequencer against a table-driven slice model.
module tb_bit_field_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] words_done;

    bit_field_sequencer_if bus ();

    bit_field_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          tbl_lsb [4];
    int          tbl_w   [4];
    int          wd_model = 0;
    int          checks = 0;
    int          failures = 0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted word becomes the ordered list of its enabled fields.
    task automatic model_accept(input logic [31:0] word);
        int en[$];
        for (int i = 0; i < 4; i++) if (tbl_w[i] != 0) en.push_back(i);
        if (en.size() == 0) begin
            wd_model++;
        end else begin
            foreach (en[k]) begin
                exp_t e;
                logic [63:0] v;
                v = (64'(word) >> tbl_lsb[en[k]]) & ((64'd1 << tbl_w[en[k]]) - 64'd1);
                e.data = v[15:0];
                e.idx  = 2'(en[k]);
                e.last = (k == en.size() - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                tbl_lsb[i] = 0;
                tbl_w[i]   = 0;
            end
            wd_model = 0;
        end else begin
            logic exp_in_ready;
            exp_in_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
            chk("words_done", 32'(words_done), 32'(wd_model[15:0]));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
                chk("out_idx", 32'(bus.out_idx), 32'(exp_q[0].idx));
                chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                if (bus.out_ready) begin
                    if (exp_q[0].last) wd_model++;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && exp_in_ready) model_accept(bus.in_data);
            if (bus.cfg_we) begin
                tbl_lsb[bus.cfg_idx] = int'(bus.cfg_lsb);
                tbl_w[bus.cfg_idx]   = (bus.cfg_width > 5'd16) ? 16 : int'(bus.cfg_width);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic cfg_write(input int idx, input int lsb, input int wid);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 2'(idx);
        bus.cfg_lsb = 5'(lsb);
        bus.cfg_width = 5'(wid);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    // Holds in_valid until the word is taken; an optional table write rides on the first cycle.
    task automatic send_word(input logic [31:0] data, input bit wr, input int idx, input int lsb, input int wid);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.cfg_we   = wr;
        bus.cfg_idx  = 2'(idx);
        bus.cfg_lsb  = 5'(lsb);
        bus.cfg_width = 5'(wid);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            bus.cfg_we = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            failures++;
            $display("FAIL send_word_timeout actual=no_accept required=accept at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0 at %0t", exp_q.size(), $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
        chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_words_done"}, 32'(words_done), 32'd0);
    endtask

    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_lsb = '0;
        bus.cfg_width = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single field: in1[19:4]-style extraction.
        cfg_write(0, 4, 16);
        send_word(32'hABCD1234, 1'b0, 0, 0, 0);
        wait_idle();

        // Disabled entry 1 is skipped; top field runs past bit 31.
        cfg_write(0, 0, 8);
        cfg_write(2, 28, 8);
        send_word(32'hABCD1234, 1'b0, 0, 0, 0);
        wait_idle();

        // Width above OUT_W clamps.
        cfg_write(0, 8, 20);
        cfg_write(2, 0, 0);
        send_word(32'hFFFFFFFF, 1'b0, 0, 0, 0);
        wait_idle();

        // Back-to-back words with two fields each.
        cfg_write(0, 0, 8);
        cfg_write(1, 8, 8);
        send_word(32'h11223344, 1'b0, 0, 0, 0);
        send_word(32'h55667788, 1'b0, 0, 0, 0);
        wait_idle();

        // Table write on the accept cycle only affects the following word.
        send_word(32'hCAFEF00D, 1'b1, 0, 16, 12);
        send_word(32'hCAFEF00D, 1'b0, 0, 0, 0);
        wait_idle();

        // No enabled entries: words are swallowed and counted.
        for (int i = 0; i < 4; i++) cfg_write(i, 0, 0);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 0, 0, 0);
        wait_idle();

        // Random traffic, stalls and table writes at any time.
        rand_rdy = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_data = $urandom;
            bus.cfg_we = ($urandom_range(0, 3) == 0);
            bus.cfg_idx = 2'($urandom_range(0, 3));
            bus.cfg_lsb = 5'($urandom_range(0, 31));
            bus.cfg_width = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        wait_idle();
        rand_rdy = 1'b0;

        // Asynchronous reset in the middle of a four-slice word.
        for (int i = 0; i < 4; i++) cfg_write(i, i * 4, 8);
        send_word(32'h89ABCDEF, 1'b0, 0, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_emit");
        @(posedge clk);
        #1;
        reset = 1'b0;

        cfg_write(3, 20, 16);
        send_word(32'h0F0F5A5A, 1'b0, 0, 0, 0);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
